intt_gs_butterfly: RTL

// Pipelined Gentleman-Sande inverse-NTT butterfly, the inverse counterpart of the forward Cooley-Tukey butterfly.

---
 rtl/intt_gs_butterfly.sv | 134 +++++++++++++
 1 files changed

// File: rtl/intt_gs_butterfly.sv
// intt_gs_butterfly: pipelined Gentleman-Sande inverse-NTT butterfly, EVEN=(A+B) mod q, ODD=(A-B)*W mod q.
// Define INTT_HALVE_EN to scale both results by 2^-1 mod q ahead of the output register.
module intt_gs_butterfly #(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 4,
  parameter int TAG_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] q,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_w,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_even,
  output logic [DATA_W-1:0] out_odd,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);
  localparam int CNT_W = $clog2(MUL_LAT + 4);

  logic [DATA_W:0]   sum_wide;
  logic [DATA_W-1:0] sum0;
  logic [DATA_W-1:0] diff0;

  always_comb begin
    sum_wide = {1'b0, in_a} + {1'b0, in_b};
    if (sum_wide >= {1'b0, q}) sum_wide = sum_wide - {1'b0, q};
    sum0  = sum_wide[DATA_W-1:0];
    diff0 = in_a - in_b;
    if (in_a < in_b) diff0 = diff0 + q;
  end

  logic [DATA_W-1:0] s1_sum, s1_diff, s1_w;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sum   <= '0;
      s1_diff  <= '0;
      s1_w     <= '0;
      s1_tag   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_sum   <= sum0;
      s1_diff  <= diff0;
      s1_w     <= in_w;
      s1_tag   <= in_tag;
      s1_valid <= in_valid;
    end
  end

  // Modular product stands in for the shared ModMult: formed in its first stage, then delayed to MUL_LAT.
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mul_res;
  assign prod    = {{DATA_W{1'b0}}, s1_diff} * {{DATA_W{1'b0}}, s1_w};
  assign mul_res = DATA_W'(prod % {{DATA_W{1'b0}}, q});

  logic [DATA_W-1:0] mul_pipe [MUL_LAT];
  logic [DATA_W-1:0] sum_pipe [MUL_LAT];
  logic [TAG_W-1:0]  tag_pipe [MUL_LAT];
  logic [MUL_LAT-1:0] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        mul_pipe[i] <= '0;
        sum_pipe[i] <= '0;
        tag_pipe[i] <= '0;
      end
      vld_pipe <= '0;
    end else begin
      mul_pipe[0] <= mul_res;
      sum_pipe[0] <= s1_sum;
      tag_pipe[0] <= s1_tag;
      vld_pipe[0] <= s1_valid;
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_pipe[i] <= mul_pipe[i-1];
        sum_pipe[i] <= sum_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

`ifdef INTT_HALVE_EN
  function automatic logic [DATA_W-1:0] halve(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] m);
    logic [DATA_W:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return DATA_W'(t >> 1);
  endfunction
`endif

  logic [DATA_W-1:0] even_fin, odd_fin;

  always_comb begin
`ifdef INTT_HALVE_EN
    even_fin = halve(sum_pipe[MUL_LAT-1], q);
    odd_fin  = halve(mul_pipe[MUL_LAT-1], q);
`else
    even_fin = sum_pipe[MUL_LAT-1];
    odd_fin  = mul_pipe[MUL_LAT-1];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_even  <= '0;
      out_odd   <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= vld_pipe[MUL_LAT-1];
      if (vld_pipe[MUL_LAT-1]) begin
        out_even <= even_fin;
        out_odd  <= odd_fin;
        out_tag  <= tag_pipe[MUL_LAT-1];
      end
    end
  end

  logic [CNT_W-1:0] in_flight;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      in_flight <= '0;
    else if (in_valid && !out_valid) in_flight <= in_flight + CNT_W'(1);
    else if (!in_valid && out_valid) in_flight <= in_flight - CNT_W'(1);
  end

  assign busy = (in_flight != '0);
endmodule
